// File: rtl/wb_stage.sv
// Writeback stage: holds one instruction from the memory stage for a single
// cycle, retires it into the register file, and maintains the retirement
// counters. A small RUN/HALTED controller lets a debugger stop retirement.
module wb_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [69:0] mem_wb_bus_in,
    input  logic        ms_to_ws_valid,
    output logic        ws_allowin,
    input  logic        halt_req,
    input  logic        resume_req,
    output logic        halted,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] debug_wb_pc,
    output logic [31:0] last_retired_pc,
    output logic [63:0] instret,
    output logic [63:0] cycle
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t      state_r;
    logic        halted_r;
    logic        ws_valid_r;
    logic [69:0] bus_r;
    logic [31:0] last_pc_r;
    logic [63:0] instret_r;
    logic [63:0] cycle_r;

    logic [4:0]  rd_s;
    logic        rd_wen_s;
    logic [31:0] wb_data_s;
    logic [31:0] pc_s;

    assign rd_s      = bus_r[69:65];
    assign rd_wen_s  = bus_r[64];
    assign wb_data_s = bus_r[63:32];
    assign pc_s      = bus_r[31:0];

    // The stage only accepts new work while retirement is running.
    assign ws_allowin = (state_r == ST_RUN);

    // Debug run/halt controller; each state listens to only one request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_RUN;
            halted_r <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (halt_req) begin
                        state_r  <= ST_HALTED;
                        halted_r <= 1'b1;
                    end else begin
                        state_r  <= ST_RUN;
                        halted_r <= 1'b0;
                    end
                end
                ST_HALTED: begin
                    if (resume_req) begin
                        state_r  <= ST_RUN;
                        halted_r <= 1'b0;
                    end else begin
                        state_r  <= ST_HALTED;
                        halted_r <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= ST_RUN;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    // Stage register: capture a valid instruction when allowed, otherwise drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ws_valid_r <= 1'b0;
            bus_r      <= 70'd0;
        end else if (ws_allowin) begin
            ws_valid_r <= ms_to_ws_valid;
            if (ms_to_ws_valid) begin
                bus_r <= mem_wb_bus_in;
            end else begin
                bus_r <= bus_r;
            end
        end else begin
            ws_valid_r <= 1'b0;
            bus_r      <= bus_r;
        end
    end

    // Retirement bookkeeping: every valid cycle in the stage is a retire cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_pc_r <= 32'd0;
            instret_r <= 64'd0;
        end else if (ws_valid_r) begin
            last_pc_r <= pc_s;
            instret_r <= instret_r + 64'd1;
        end else begin
            last_pc_r <= last_pc_r;
            instret_r <= instret_r;
        end
    end

    // Free-running cycle counter, counts in both RUN and HALTED.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_r <= 64'd0;
        end else begin
            cycle_r <= cycle_r + 64'd1;
        end
    end

    // Outputs are decoded purely from registered state; x0 is never written.
    assign rf_we           = ws_valid_r & rd_wen_s & (rd_s != 5'd0);
    assign rf_waddr        = rd_s;
    assign rf_wdata        = wb_data_s;
    assign debug_wb_pc     = ws_valid_r ? pc_s : 32'd0;
    assign halted          = halted_r;
    assign last_retired_pc = last_pc_r;
    assign instret         = instret_r;
    assign cycle           = cycle_r;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a behavioural model of the stage contents and
// counters is compared against the DUT every cycle, and directed scenarios
// check hand-computed values at key points.
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic [69:0] mem_wb_bus_in;
    logic        ms_to_ws_valid;
    logic        ws_allowin;
    logic        halt_req;
    logic        resume_req;
    logic        halted;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] debug_wb_pc;
    logic [31:0] last_retired_pc;
    logic [63:0] instret;
    logic [63:0] cycle;

    int total = 0;
    int bad   = 0;

    wb_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_wb_bus_in   (mem_wb_bus_in),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ws_allowin      (ws_allowin),
        .halt_req        (halt_req),
        .resume_req      (resume_req),
        .halted          (halted),
        .rf_we           (rf_we),
        .rf_waddr        (rf_waddr),
        .rf_wdata        (rf_wdata),
        .debug_wb_pc     (debug_wb_pc),
        .last_retired_pc (last_retired_pc),
        .instret         (instret),
        .cycle           (cycle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The model tracks "which instruction is in the stage" and "is the debugger
    // holding us", and derives every output from those facts.
    logic        m_started = 1'b0;
    logic        m_halted  = 1'b0;
    logic        m_occupied = 1'b0;
    logic [4:0]  m_rd = 5'd0;
    logic        m_wen = 1'b0;
    logic [31:0] m_data = 32'd0;
    logic [31:0] m_pc = 32'd0;
    logic [31:0] m_last = 32'd0;
    logic [63:0] m_instret = 64'd0;
    logic [63:0] m_cycle = 64'd0;

    // Model update at each rising edge, from the inputs seen at that edge.
    always @(posedge clk) begin
        m_started <= 1'b1;
        if (!rst_n) begin
            m_halted   <= 1'b0;
            m_occupied <= 1'b0;
            m_rd <= 5'd0; m_wen <= 1'b0; m_data <= 32'd0; m_pc <= 32'd0;
            m_last <= 32'd0; m_instret <= 64'd0; m_cycle <= 64'd0;
        end else begin
            m_cycle <= m_cycle + 64'd1;
            if (m_occupied) begin
                m_instret <= m_instret + 64'd1;
                m_last    <= m_pc;
            end
            if (!m_halted && ms_to_ws_valid) begin
                m_occupied <= 1'b1;
                m_rd   <= mem_wb_bus_in[69:65];
                m_wen  <= mem_wb_bus_in[64];
                m_data <= mem_wb_bus_in[63:32];
                m_pc   <= mem_wb_bus_in[31:0];
            end else begin
                m_occupied <= 1'b0;
            end
            if (m_halted) m_halted <= !resume_req;
            else          m_halted <= halt_req;
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (m_started) begin
            chk("allowin", {63'd0, ws_allowin}, {63'd0, !m_halted});
            chk("halted",  {63'd0, halted}, {63'd0, m_halted});
            chk("rf_we",   {63'd0, rf_we}, {63'd0, m_occupied && m_wen && (m_rd != 5'd0)});
            chk("waddr",   {59'd0, rf_waddr}, {59'd0, m_rd});
            chk("wdata",   {32'd0, rf_wdata}, {32'd0, m_data});
            chk("dbg_pc",  {32'd0, debug_wb_pc}, {32'd0, (m_occupied ? m_pc : 32'd0)});
            chk("last_pc", {32'd0, last_retired_pc}, {32'd0, m_last});
            chk("instret", instret, m_instret);
            chk("cycle",   cycle, m_cycle);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present one instruction for exactly one edge, then go idle.
    task automatic send(input logic [4:0] rd, input logic wen, input logic [31:0] d,
                        input logic [31:0] pc);
        mem_wb_bus_in  = {rd, wen, d, pc};
        ms_to_ws_valid = 1'b1;
        tick();
        ms_to_ws_valid = 1'b0;
    endtask

    logic [63:0] cyc_snap;

    initial begin
        rst_n = 1'b0;
        mem_wb_bus_in = 70'd0;
        ms_to_ws_valid = 1'b0;
        halt_req = 1'b0;
        resume_req = 1'b0;
        tick();
        tick();
        chk("rst_we",      {63'd0, rf_we}, 64'd0);
        chk("rst_allowin", {63'd0, ws_allowin}, 64'd1);
        chk("rst_instret", instret, 64'd0);
        rst_n = 1'b1;

        // Three back-to-back writes.
        send(5'd5, 1'b1, 32'hAAAA_0005, 32'h0000_0100);
        chk("b2b_we0", {63'd0, rf_we}, 64'd1);
        chk("b2b_wa0", {59'd0, rf_waddr}, 64'd5);
        chk("b2b_pc0", {32'd0, debug_wb_pc}, 64'h100);
        send(5'd6, 1'b1, 32'hAAAA_0006, 32'h0000_0104);
        chk("b2b_we1", {63'd0, rf_we}, 64'd1);
        chk("b2b_wa1", {59'd0, rf_waddr}, 64'd6);
        send(5'd7, 1'b1, 32'hAAAA_0007, 32'h0000_0108);
        chk("b2b_we2", {63'd0, rf_we}, 64'd1);
        chk("b2b_wd2", {32'd0, rf_wdata}, 64'hAAAA_0007);
        tick();
        chk("b2b_idle_we", {63'd0, rf_we}, 64'd0);
        chk("b2b_instret", instret, 64'd3);
        chk("b2b_last",    {32'd0, last_retired_pc}, 64'h108);
        chk("b2b_dbg0",    {32'd0, debug_wb_pc}, 64'd0);

        // Write to x0 retires but never writes.
        send(5'd0, 1'b1, 32'hDEAD_BEEF, 32'h0000_0140);
        chk("x0_we",  {63'd0, rf_we}, 64'd0);
        chk("x0_dbg", {32'd0, debug_wb_pc}, 64'h140);
        tick();
        chk("x0_instret", instret, 64'd4);

        // rd_wen=0 still counts as a retirement.
        send(5'd31, 1'b0, 32'h1234_5678, 32'h0000_0150);
        chk("nowen_we", {63'd0, rf_we}, 64'd0);
        chk("nowen_wa", {59'd0, rf_waddr}, 64'd31);
        tick();
        chk("nowen_instret", instret, 64'd5);

        // Halt while 0x200 is held: it still retires.
        send(5'd9, 1'b1, 32'h0000_0009, 32'h0000_0200);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("halt_halted",  {63'd0, halted}, 64'd1);
        chk("halt_allowin", {63'd0, ws_allowin}, 64'd0);
        chk("halt_last",    {32'd0, last_retired_pc}, 64'h200);
        chk("halt_instret", instret, 64'd6);
        cyc_snap = cycle;
        mem_wb_bus_in  = {5'd10, 1'b1, 32'h0000_0010, 32'h0000_0300};
        ms_to_ws_valid = 1'b1;
        tick();
        tick();
        chk("halt_frozen", instret, 64'd6);
        chk("halt_cycle",  cycle, cyc_snap + 64'd2);
        chk("halt_noacc",  {32'd0, debug_wb_pc}, 64'd0);
        resume_req = 1'b1;
        tick();
        resume_req = 1'b0;
        chk("res_halted",  {63'd0, halted}, 64'd0);
        chk("res_allowin", {63'd0, ws_allowin}, 64'd1);
        tick();
        ms_to_ws_valid = 1'b0;
        chk("res_dbg", {32'd0, debug_wb_pc}, 64'h300);
        chk("res_wa",  {59'd0, rf_waddr}, 64'd10);
        tick();
        chk("res_instret", instret, 64'd7);

        // Both requests high for two edges: halt, then resume.
        halt_req = 1'b1;
        resume_req = 1'b1;
        tick();
        chk("both_e1", {63'd0, halted}, 64'd1);
        tick();
        chk("both_e2", {63'd0, halted}, 64'd0);
        halt_req = 1'b0;
        resume_req = 1'b0;
        tick();
        chk("both_e3", {63'd0, halted}, 64'd0);

        // instret wrap via deposit.
        send(5'd12, 1'b1, 32'h0000_0012, 32'h0000_0500);
        force dut.instret_r = 64'hFFFF_FFFF_FFFF_FFFF;
        m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_r;
        chk("wrap_pre", instret, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        chk("wrap_post", instret, 64'd0);
        chk("wrap_last", {32'd0, last_retired_pc}, 64'h500);

        // Reset mid-stream discards the held instruction.
        send(5'd3, 1'b1, 32'h0000_0003, 32'h0000_0400);
        chk("mid_held", {63'd0, rf_we}, 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_we",      {63'd0, rf_we}, 64'd0);
        chk("mid_instret", instret, 64'd0);
        chk("mid_cycle",   cycle, 64'd0);
        chk("mid_last",    {32'd0, last_retired_pc}, 64'd0);
        chk("mid_dbg",     {32'd0, debug_wb_pc}, 64'd0);
        tick();
        chk("mid_cycle1",  cycle, 64'd1);
        chk("mid_instret1", instret, 64'd0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
